// File: rtl/serial_frame_receiver.sv
// Serial frame receiver: start bit, WIDTH data bits, optional even parity, stop bit.
// Good words land in a one-deep valid/ready buffer; bad or dropped frames pulse a flag.
module serial_frame_receiver #(
    parameter int WIDTH     = 4,
    parameter int PARITY_EN = 1,
    parameter int LSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_en,
    input  logic             serial_in,
    input  logic             ready,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    output logic             busy,
    output logic             parity_err,
    output logic             frame_err,
    output logic             overrun,
    output logic [1:0]       state_dbg
);

    // Handshake: a word transfers on any rising edge where valid=1 and ready=1;
    // valid never drops without a transfer (or reset), and ready is ignored while valid=0.

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             par_q, par_d;
    logic             parity_bad_q, parity_bad_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             parity_err_q, parity_err_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
    logic             pop;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shreg_d      = shreg_q;
        par_d        = par_q;
        parity_bad_d = parity_bad_q;
        data_d       = data_q;
        valid_d      = valid_q;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;
        overrun_d    = 1'b0;
        pop          = valid_q && ready;

        if (pop) valid_d = 1'b0;

        if (bit_en) begin
            case (state_q)
                IDLE: begin
                    if (!serial_in) begin
                        state_d      = DATA;
                        cnt_d        = '0;
                        par_d        = 1'b0;
                        parity_bad_d = 1'b0;
                    end
                end
                DATA: begin
                    if (LSB_FIRST != 0) shreg_d = {serial_in, shreg_q[WIDTH-1:1]};
                    else                shreg_d = {shreg_q[WIDTH-2:0], serial_in};
                    par_d = par_q ^ serial_in;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BIT) begin
                        if (PARITY_EN != 0) state_d = PARITY;
                        else                state_d = STOP;
                    end
                end
                PARITY: begin
                    parity_bad_d = par_q ^ serial_in;
                    state_d      = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    // A bad stop bit outranks a parity failure.
                    if (!serial_in) begin
                        frame_err_d = 1'b1;
                    end else if (parity_bad_q) begin
                        parity_err_d = 1'b1;
                    end else if (!valid_q || pop) begin
                        data_d  = shreg_q;
                        valid_d = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            shreg_q      <= '0;
            par_q        <= 1'b0;
            parity_bad_q <= 1'b0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shreg_q      <= shreg_d;
            par_q        <= par_d;
            parity_bad_q <= parity_bad_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign data_out   = data_q;
    assign valid      = valid_q;
    assign busy       = (state_q != IDLE);
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign state_dbg  = state_q;

endmodule

// File: doc/serial_frame_receiver.md
# serial_frame_receiver

Serial-to-parallel frame receiver that sits directly downstream of the 4-bit universal shift register. It consumes the register's serial output bitstream and detects a start bit. It then assembles WIDTH data bits, checks optional even parity and the stop bit, and presents each good word through a one-deep valid/ready output buffer.

## Interface
- WIDTH, default 4: data bits per frame; matches the shift register width.
- PARITY_EN, default 1: 1 means an even-parity bit follows the data; 0 means no parity bit.
- LSB_FIRST, default 1: 1 means the first data bit received is data_out[0]; 0 means it is data_out[WIDTH-1].
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- bit_en  input  1  bit strobe; serial_in is sampled only on edges where bit_en=1.
- serial_in  input  1  serial line; idle level 1.
- ready  input  1  consumer accepts data_out when valid=1 and ready=1.
- data_out  output  WIDTH  received word; stable while valid=1.
- valid  output  1  data_out holds an unconsumed word.
- busy  output  1  a frame is in progress (state ≠ IDLE).
- parity_err  output  1  one-cycle pulse: frame discarded because parity failed.
- frame_err  output  1  one-cycle pulse: frame discarded because the stop bit was 0.
- overrun  output  1  one-cycle pulse: good frame dropped because the buffer was full.

## Operation
- Frame format: start bit (0), then WIDTH data bits, then a parity bit if PARITY_EN=1, then the stop bit (1).
- States: IDLE, DATA, PARITY, STOP. The FSM advances only on edges where bit_en=1; with bit_en=0 all FSM state and the bit counter hold.
- IDLE → DATA when serial_in=0 is sampled; the bit counter is cleared. A sampled 1 keeps the FSM in IDLE.
- DATA: shift serial_in into the assembly register and increment the bit counter.
  - After the WIDTH-th bit, go to PARITY if PARITY_EN=1, otherwise go to STOP.
  - The running parity is the XOR of the data bits.
- PARITY: sample the parity bit; set an internal parity_bad flag if (data XOR parity bit) ≠ 0. Go to STOP.
- STOP: sample the stop bit, then return to IDLE in all cases.
  - Stop bit 0: pulse frame_err and discard the frame. frame_err takes priority over parity_err.
  - Stop bit 1 and parity_bad: pulse parity_err and discard the frame.
  - Stop bit 1 and parity good: the frame is good.
    - Buffer empty, or being popped on the same edge: load data_out and set valid=1.
    - Buffer full and not popped: drop the new word, pulse overrun, leave data_out unchanged.
- Pop: on an edge with valid=1 and ready=1, valid clears, unless a good frame loads on the same edge, in which case valid stays 1 with the new data.
- ready is ignored when valid=0.
- After a discarded frame the FSM is in IDLE; the next sampled 0 starts a new frame.

## Timing
- Reset (rst=1 at a rising edge) forces:
  - FSM to IDLE; bit counter, assembly register and parity_bad to 0.
  - data_out=0, valid=0, busy=0, parity_err=0, frame_err=0, overrun=0.
- Reset takes priority over every other event. Asserting it mid-frame abandons the frame and drops any buffered word.
- With bit_en held high, a frame occupies WIDTH+2+PARITY_EN consecutive edges.
- valid, parity_err, frame_err and overrun all become visible in the cycle after the edge that samples the stop bit.
- Error and overrun pulses last exactly one cycle.
- busy goes high in the cycle after the start-bit edge and goes low in the cycle after the stop-bit edge.
- A start bit may be sampled on the edge immediately following the stop-bit edge, so frames can run back to back with no idle bits.

## Test plan
- Reset: hold rst=1 for 2 edges with serial_in toggling → all outputs 0, busy=0; release → remains IDLE while serial_in=1.
- Good frame (WIDTH=4, LSB_FIRST=1, PARITY_EN=1, bit_en=1): send 0, 0,1,0,1, 0, 1 → data_out=4'hA and valid=1 one cycle after the stop edge; valid held with ready=0; clears the cycle after an edge with ready=1.
- Parity error: send 0, 1,1,0,0, 1, 1 → parity_err single-cycle pulse, valid stays 0, busy=0 afterwards.
- Framing error: send 0, 1,0,0,0, 1, 0 → frame_err pulse only (no parity_err), valid=0; a following good frame of 4'h3 → data_out=4'h3.
- Overrun and simultaneous pop: with ready=0, send frames 4'h5 then 4'h9 → data_out stays 5, one overrun pulse. Repeat with ready=1 on the second stop edge → data_out=9, valid stays 1, no overrun.
- bit_en gaps and reset mid-frame: toggle bit_en every other cycle → same result as the good-frame case. Then assert rst after 2 data bits → busy=0 and valid=0 the next cycle; a subsequent 4'hC frame is received correctly.
